// File: rtl/ysyx_22041071_pc_gen.sv
// Fetch-PC generator for the ysyx_22041071 RV64 core: issues the fetch PC on a
// valid/ready handshake and applies trap, branch/jump and halt control.
module ysyx_22041071_pc_gen #(
  parameter int unsigned            ADDR_W     = 64,
  parameter logic [ADDR_W-1:0]      START_ADDR = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              redir_valid_i,
  input  logic [ADDR_W-1:0] redir_pc_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              halt_i,
  output logic              flush_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic [63:0]       fetch_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_TRAP = 2'd2,
    ST_HALT      = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  // A fetch target is legal only when word aligned.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    is_aligned = (addr[1:0] == 2'b00);
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic                valid_r, valid_s;
  logic                flush_r, flush_s;
  logic                misalign_r, misalign_s;
  logic [ADDR_W-1:0]   bad_addr_r, bad_addr_s;
  logic [63:0]         cnt_r, cnt_s;
  logic                fire_s;

  // Next-state, next-PC and pulse generation.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    flush_s    = 1'b0;
    misalign_s = 1'b0;
    bad_addr_s = bad_addr_r;
    cnt_s      = cnt_r;
    fire_s     = valid_r & ready_i & (state_r == ST_RUN);

    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
        pc_s    = START_ADDR;
      end
      ST_RUN: begin
        // The handshake counts even when a redirect replaces the next PC.
        if (fire_s) begin
          cnt_s = cnt_r + 64'd1;
        end else begin
          cnt_s = cnt_r;
        end
        if (halt_i) begin
          state_s = ST_HALT;
        end else if (trap_valid_i) begin
          pc_s    = trap_pc_i;
          flush_s = 1'b1;
        end else if (redir_valid_i && is_aligned(redir_pc_i)) begin
          pc_s    = redir_pc_i;
          flush_s = 1'b1;
        end else if (redir_valid_i) begin
          misalign_s = 1'b1;
          bad_addr_s = redir_pc_i;
          flush_s    = 1'b1;
          state_s    = ST_WAIT_TRAP;
        end else if (fire_s) begin
          pc_s = pc_r + PC_STEP;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_WAIT_TRAP: begin
        // Only the trap unit (or halt) can restart fetch after a bad target.
        if (halt_i) begin
          state_s = ST_HALT;
        end else if (trap_valid_i) begin
          pc_s    = trap_pc_i;
          flush_s = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_WAIT_TRAP;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_BOOT;
        pc_s    = START_ADDR;
      end
    endcase

    valid_s = (state_s == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_BOOT;
      pc_r       <= START_ADDR;
      valid_r    <= 1'b0;
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      bad_addr_r <= {ADDR_W{1'b0}};
      cnt_r      <= 64'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      valid_r    <= valid_s;
      flush_r    <= flush_s;
      misalign_r <= misalign_s;
      bad_addr_r <= bad_addr_s;
      cnt_r      <= cnt_s;
    end
  end

  assign valid_o     = valid_r;
  assign pc_o        = pc_r;
  assign flush_o     = flush_r;
  assign misalign_o  = misalign_r;
  assign bad_addr_o  = bad_addr_r;
  assign fetch_cnt_o = cnt_r;

endmodule

// File: tb/tb_ysyx_22041071_pc_gen.sv
// Directed self-checking bench for ysyx_22041071_pc_gen.
module tb_ysyx_22041071_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready_i;
  logic        valid_o;
  logic [63:0] pc_o;
  logic        redir_valid_i;
  logic [63:0] redir_pc_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic        halt_i;
  logic        flush_o;
  logic        misalign_o;
  logic [63:0] bad_addr_o;
  logic [63:0] fetch_cnt_o;

  int tests  = 0;
  int errors = 0;

  ysyx_22041071_pc_gen dut (
    .clk(clk), .reset(reset), .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .halt_i(halt_i),
    .flush_o(flush_o), .misalign_o(misalign_o), .bad_addr_o(bad_addr_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    redir_valid_i = 1'b0; redir_pc_i = 64'd0;
    trap_valid_i  = 1'b0; trap_pc_i  = 64'd0;
    halt_i        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_i = 1'b0; clear_ctrl();
    step(); step();
    tests++; if (pc_o !== 64'h8000_0000) begin $display("FAIL reset_pc got %h exp %h", pc_o, 64'h8000_0000); errors++; end
    tests++; if (valid_o !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", valid_o); errors++; end
    tests++; if (flush_o !== 1'b0 || misalign_o !== 1'b0) begin $display("FAIL reset_pulses got %b%b exp 00", flush_o, misalign_o); errors++; end
    tests++; if (bad_addr_o !== 64'd0 || fetch_cnt_o !== 64'd0) begin $display("FAIL reset_regs got %h %h exp 0 0", bad_addr_o, fetch_cnt_o); errors++; end
  endtask

  task automatic test_boot_run();
    logic [63:0] exp_pc;
    reset = 1'b0; ready_i = 1'b1;
    step();
    exp_pc = 64'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      tests++; if (valid_o !== 1'b1 || pc_o !== exp_pc) begin $display("FAIL run_seq[%0d] got v=%b pc=%h exp v=1 pc=%h", i, valid_o, pc_o, exp_pc); errors++; end
      tests++; if (fetch_cnt_o !== 64'(i)) begin $display("FAIL run_cnt[%0d] got %0d exp %0d", i, fetch_cnt_o, i); errors++; end
      exp_pc = exp_pc + 64'd4;
      step();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tests++; if (pc_o !== 64'h8000_0010 || valid_o !== 1'b1 || fetch_cnt_o !== 64'd4) begin
        $display("FAIL stall[%0d] got pc=%h v=%b cnt=%0d exp pc=80000010 v=1 cnt=4", i, pc_o, valid_o, fetch_cnt_o); errors++; end
      step();
    end
  endtask

  task automatic test_redirect();
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0100;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'h8000_0100 || flush_o !== 1'b1 || valid_o !== 1'b1) begin
      $display("FAIL redir got pc=%h fl=%b v=%b exp pc=80000100 fl=1 v=1", pc_o, flush_o, valid_o); errors++; end
    tests++; if (fetch_cnt_o !== 64'd4) begin $display("FAIL redir_cnt got %0d exp 4", fetch_cnt_o); errors++; end
    step();
    tests++; if (flush_o !== 1'b0 || pc_o !== 64'h8000_0100) begin $display("FAIL redir_after got fl=%b pc=%h exp fl=0 pc=80000100", flush_o, pc_o); errors++; end
  endtask

  task automatic test_misalign();
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0102;
    step(); clear_ctrl();
    tests++; if (misalign_o !== 1'b1 || valid_o !== 1'b0 || bad_addr_o !== 64'h8000_0102 || flush_o !== 1'b1 || pc_o !== 64'h8000_0100) begin
      $display("FAIL misalign got m=%b v=%b bad=%h fl=%b pc=%h exp m=1 v=0 bad=80000102 fl=1 pc=80000100", misalign_o, valid_o, bad_addr_o, flush_o, pc_o); errors++; end
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0200;
    step(); clear_ctrl();
    tests++; if (misalign_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 64'h8000_0100 || flush_o !== 1'b0 || bad_addr_o !== 64'h8000_0102) begin
      $display("FAIL wait_trap got m=%b v=%b pc=%h fl=%b bad=%h exp m=0 v=0 pc=80000100 fl=0 bad=80000102", misalign_o, valid_o, pc_o, flush_o, bad_addr_o); errors++; end
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0800;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'h8000_0800 || valid_o !== 1'b1 || flush_o !== 1'b1) begin
      $display("FAIL trap_exit got pc=%h v=%b fl=%b exp pc=80000800 v=1 fl=1", pc_o, valid_o, flush_o); errors++; end
  endtask

  task automatic test_priority();
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0900;
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0100;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'h8000_0900 || flush_o !== 1'b1) begin $display("FAIL trap_over_redir got pc=%h fl=%b exp pc=80000900 fl=1", pc_o, flush_o); errors++; end
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0A00;
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0102;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'h8000_0A00 || misalign_o !== 1'b0 || valid_o !== 1'b1 || bad_addr_o !== 64'h8000_0102) begin
      $display("FAIL trap_over_misalign got pc=%h m=%b v=%b bad=%h exp pc=80000a00 m=0 v=1 bad=80000102", pc_o, misalign_o, valid_o, bad_addr_o); errors++; end
  endtask

  task automatic test_wrap();
    redir_valid_i = 1'b1; redir_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin $display("FAIL wrap_pre got %h exp fffffffffffffffc", pc_o); errors++; end
    ready_i = 1'b1;
    step(); ready_i = 1'b0;
    tests++; if (pc_o !== 64'd0 || valid_o !== 1'b1 || fetch_cnt_o !== 64'd5 || misalign_o !== 1'b0) begin
      $display("FAIL wrap got pc=%h v=%b cnt=%0d m=%b exp pc=0 v=1 cnt=5 m=0", pc_o, valid_o, fetch_cnt_o, misalign_o); errors++; end
  endtask

  task automatic test_back_to_back();
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_1000;
    step();
    tests++; if (pc_o !== 64'h8000_1000 || flush_o !== 1'b1) begin $display("FAIL b2b_first got pc=%h fl=%b exp pc=80001000 fl=1", pc_o, flush_o); errors++; end
    redir_pc_i = 64'h8000_2000;
    step(); clear_ctrl();
    tests++; if (pc_o !== 64'h8000_2000 || flush_o !== 1'b1) begin $display("FAIL b2b_second got pc=%h fl=%b exp pc=80002000 fl=1", pc_o, flush_o); errors++; end
    step();
    tests++; if (flush_o !== 1'b0 || fetch_cnt_o !== 64'd5) begin $display("FAIL b2b_end got fl=%b cnt=%0d exp fl=0 cnt=5", flush_o, fetch_cnt_o); errors++; end
  endtask

  task automatic test_halt();
    halt_i = 1'b1; trap_valid_i = 1'b1; trap_pc_i = 64'h8000_3000;
    step(); clear_ctrl();
    tests++; if (valid_o !== 1'b0 || pc_o !== 64'h8000_2000 || flush_o !== 1'b0) begin
      $display("FAIL halt got v=%b pc=%h fl=%b exp v=0 pc=80002000 fl=0", valid_o, pc_o, flush_o); errors++; end
    ready_i = 1'b1; trap_valid_i = 1'b1; trap_pc_i = 64'h8000_4000;
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0006;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (valid_o !== 1'b0 || pc_o !== 64'h8000_2000 || fetch_cnt_o !== 64'd5 || misalign_o !== 1'b0 || flush_o !== 1'b0) begin
        $display("FAIL halt_hold[%0d] got v=%b pc=%h cnt=%0d m=%b fl=%b exp v=0 pc=80002000 cnt=5 m=0 fl=0", i, valid_o, pc_o, fetch_cnt_o, misalign_o, flush_o); errors++; end
    end
    clear_ctrl(); ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    tests++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000 || fetch_cnt_o !== 64'd0) begin
      $display("FAIL halt_reset got v=%b pc=%h cnt=%0d exp v=1 pc=80000000 cnt=0", valid_o, pc_o, fetch_cnt_o); errors++; end
    redir_valid_i = 1'b1; redir_pc_i = 64'h8000_0006;
    step(); clear_ctrl();
    tests++; if (misalign_o !== 1'b1) begin $display("FAIL mid_misalign got %b exp 1", misalign_o); errors++; end
    reset = 1'b1;
    step();
    tests++; if (valid_o !== 1'b0 || pc_o !== 64'h8000_0000 || flush_o !== 1'b0 || misalign_o !== 1'b0 || bad_addr_o !== 64'd0 || fetch_cnt_o !== 64'd0) begin
      $display("FAIL mid_reset got v=%b pc=%h fl=%b m=%b bad=%h cnt=%0d exp v=0 pc=80000000 fl=0 m=0 bad=0 cnt=0", valid_o, pc_o, flush_o, misalign_o, bad_addr_o, fetch_cnt_o); errors++; end
    reset = 1'b0; ready_i = 1'b1;
    step();
    tests++; if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000) begin $display("FAIL reboot got v=%b pc=%h exp v=1 pc=80000000", valid_o, pc_o); errors++; end
    step();
    tests++; if (pc_o !== 64'h8000_0004 || fetch_cnt_o !== 64'd1) begin $display("FAIL reboot_step got pc=%h cnt=%0d exp pc=80000004 cnt=1", pc_o, fetch_cnt_o); errors++; end
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect();
    test_misalign();
    test_priority();
    test_wrap();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
